accel_led_driver: RTL and testbench
===================================

// Module: accel_led_driver
// PURPOSE
//  Downstream consumer of the accelerator/RAM controller status: turns ACCEL_ACTIVE,
//  MAPROM_ACTIVE and the fast-RAM chip-enable strobe into visible front-panel LED drive.
//  - Accel LED: dim glow while the accelerator owns the bus, full brightness stretched on RAM activity.
//  - MapROM LED: boot blink pattern, then steady on.
//  Runs entirely in the E-clock domain (~709 kHz); all inputs are asynchronous to it.
// PARAMETERS
//  PRESCALE_BITS  10   tick prescaler width; tick = 2^10 CLK_E (~1.44 ms)
//  HOLD_TICKS     35   activity stretch length in ticks (~50 ms)
//  PWM_BITS       4    dim PWM counter width (period 16 CLK_E)
//  DIM_DUTY       3    dim duty, CLK_E cycles high per PWM period (0..2^PWM_BITS-1)
//  BLINK_TICKS    174  MapROM blink half-period in ticks (~250 ms)
//  BLINK_COUNT    3    number of boot blinks
// PORTS
//  CLK_E          in   1  E clock, rising edge
//  RESET          in   1  asynchronous, active-low reset
//  ACCEL_ACTIVE   in   1  accelerator bus ownership, async level
//  MAPROM_ACTIVE  in   1  MapROM enabled, async level
//  RAM_CE_n       in   1  fast-RAM chip enable, async; falling edge = one access
//  LED_ACCEL      out  1  accel LED drive, active high
//  LED_MAPROM     out  1  MapROM LED drive, active high
// BEHAVIOUR
//  Reset: all flops to 0, including the RAM_CE_n toggle flop.
//    Resulting state: LED_ACCEL=0, LED_MAPROM=0, FSM=IDLE, hold=0, prescaler=0, pwm=0.
//  Sync: ACCEL_ACTIVE and MAPROM_ACTIVE each pass through a 2-flop synchronizer -> acc_s, map_s.
//  Activity capture (one access can be far shorter than a CLK_E period):
//    - ce_tgl toggles on each negedge RAM_CE_n; async cleared by RESET.
//    - 2-flop sync plus a history flop; event = sync2 ^ hist.
//    - Every access edge is reflected. Two edges inside one sync window may merge into one
//      event or none (XOR); this is acceptable for LED use.
//  Prescaler: free-running PRESCALE_BITS up-counter that wraps.
//    - tick = 1 in the cycle where the count is all ones.
//  Hold counter: 8 bits.
//    - event loads HOLD_TICKS. Event wins over a tick decrement in the same cycle (retrigger).
//    - tick with hold != 0 decrements; saturates at 0.
//  PWM: PWM_BITS counter incremented every CLK_E; dim = (pwm < DIM_DUTY).
//  LED_ACCEL (registered) <= acc_s & ((hold != 0) | dim).
//    - acc_s = 0 forces off and also clears hold.
//    - Latency: RAM_CE_n fall -> LED_ACCEL = 1 by the 4th rising CLK_E edge.
//  MapROM FSM (2-bit), with blink counter bc:
//    IDLE       LED off. map_s = 1 -> BLINK_ON; load bc = BLINK_COUNT; zero the tick counter.
//    BLINK_ON   LED on. After BLINK_TICKS ticks -> BLINK_OFF.
//    BLINK_OFF  LED off. After BLINK_TICKS ticks: bc-1. If bc-1 == 0 -> STEADY, else BLINK_ON.
//    STEADY     LED on.
//    Any state: map_s = 0 -> IDLE next cycle, LED off (priority over tick transitions).
//    BLINK_COUNT = 0 -> IDLE goes straight to STEADY.
//    LED_MAPROM registered, decoded from the next state.
//  Tick counter: 8 bits, counts ticks within a blink phase and clears on every phase change.
//  Reset mid-blink or mid-hold: immediate async clear. After release, blinking restarts from
//    BLINK_ON once map_s rises (3rd CLK_E edge if MAPROM_ACTIVE is already high).
// STRUCTURE
//  Shared defs include accel_led_defs.vh:
//    - FSM state encodings: IDLE=2'd0, BLINK_ON=2'd1, BLINK_OFF=2'd2, STEADY=2'd3.
//    - Default timing constants.
//  Sub-module accel_ce_activity_sync:
//    - ce_tgl toggle flop, 2-flop sync and history flop; output 1-cycle 'event'.
//    - Reused for future activity LEDs.
//  Top level: synchronizers, prescaler, PWM, hold counter, MapROM FSM.
// TESTING
//  1. RESET low, toggle all inputs -> LED_ACCEL = LED_MAPROM = 0, FSM = IDLE throughout.
//  2. ACCEL_ACTIVE = 1, no RAM_CE_n activity -> LED_ACCEL high exactly 3 of every 16 CLK_E.
//  3. ACCEL_ACTIVE = 1, one 60 ns RAM_CE_n low pulse -> LED_ACCEL = 1 within 4 edges,
//     held 34-35 ticks (~49-50 ms), then returns to dim PWM.
//  4. Second pulse at tick 20 of the hold -> hold reloads to 35; LED continuously on ~35 ticks more.
//  5. MAPROM_ACTIVE = 1 at reset release -> 3 on/off pulses of 174 ticks each, then steady on.
//     Drop MAPROM_ACTIVE mid-blink -> LED off 3 cycles later, FSM = IDLE.
//  6. Assert RESET during the hold and during BLINK_ON -> outputs 0 immediately;
//     no spurious activity event after release (toggle flop cleared).

Source files
------------

// File: rtl/accel_led_driver_pkg.sv
// ============================================================================
// accel_led_driver_pkg
// Shared MapROM FSM encodings, default timing constants and LED decode helper.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package accel_led_driver_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BLINK_ON  = 2'd1;
    localparam logic [1:0] ST_BLINK_OFF = 2'd2;
    localparam logic [1:0] ST_STEADY    = 2'd3;

    localparam int DEF_PRESCALE_BITS = 10;
    localparam int DEF_HOLD_TICKS    = 35;
    localparam int DEF_PWM_BITS      = 4;
    localparam int DEF_DIM_DUTY      = 3;
    localparam int DEF_BLINK_TICKS   = 174;
    localparam int DEF_BLINK_COUNT   = 3;

    function automatic logic maprom_led_on(input logic [1:0] i_state);
        return (i_state == ST_BLINK_ON) || (i_state == ST_STEADY);
    endfunction

endpackage

`default_nettype wire

// File: rtl/accel_led_driver_ce_activity_sync.sv
// ============================================================================
// accel_ce_activity_sync
// Captures chip-enable falling edges as a toggle, brings it into the clock domain, emits 1-cycle events.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module accel_ce_activity_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ce_n,
    output logic o_event
);

    logic r_tgl;
    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    // Accesses may be far shorter than a clock period, so each one flips a toggle instead.
    always_ff @(negedge i_ce_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tgl <= 1'b0;
        end else begin
            r_tgl <= ~r_tgl;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= r_tgl;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign o_event = r_sync2 ^ r_hist;

endmodule

`default_nettype wire

// File: rtl/accel_led_driver.sv
// ============================================================================
// accel_led_driver
// Front-panel LED drive: accel dim glow / activity stretch, MapROM boot blink then steady.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module accel_led_driver
    import accel_led_driver_pkg::*;
#(
    parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
    parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
    parameter int PWM_BITS      = DEF_PWM_BITS,
    parameter int DIM_DUTY      = DEF_DIM_DUTY,
    parameter int BLINK_TICKS   = DEF_BLINK_TICKS,
    parameter int BLINK_COUNT   = DEF_BLINK_COUNT
) (
    input  logic CLK_E,
    input  logic RESET,
    input  logic ACCEL_ACTIVE,
    input  logic MAPROM_ACTIVE,
    input  logic RAM_CE_n,
    output logic LED_ACCEL,
    output logic LED_MAPROM
);

    localparam logic [7:0]          c_HOLD_LOAD  = 8'(HOLD_TICKS);
    localparam logic [7:0]          c_BLINK_LAST = 8'(BLINK_TICKS - 1);
    localparam logic [7:0]          c_BC_LOAD    = 8'(BLINK_COUNT);
    localparam logic [PWM_BITS-1:0] c_DIM_DUTY   = PWM_BITS'(DIM_DUTY);

    logic                     r_acc_m, r_acc_s;
    logic                     r_map_m, r_map_s;
    logic [PRESCALE_BITS-1:0] r_presc;
    logic [PWM_BITS-1:0]      r_pwm;
    logic [7:0]               r_hold;
    logic [1:0]               r_state;
    logic [7:0]               r_tcnt;
    logic [7:0]               r_bc;

    logic                     w_event;
    logic                     w_tick;
    logic                     w_dim;
    logic                     w_phase_end;
    logic [1:0]               w_state_nxt;
    logic [7:0]               w_tcnt_nxt;
    logic [7:0]               w_bc_nxt;

    accel_ce_activity_sync u_ce_sync (
        .i_clk   (CLK_E),
        .i_rst_n (RESET),
        .i_ce_n  (RAM_CE_n),
        .o_event (w_event)
    );

    always_ff @(posedge CLK_E or negedge RESET) begin
        if (!RESET) begin
            r_acc_m <= 1'b0;
            r_acc_s <= 1'b0;
            r_map_m <= 1'b0;
            r_map_s <= 1'b0;
            r_presc <= '0;
            r_pwm   <= '0;
        end else begin
            r_acc_m <= ACCEL_ACTIVE;
            r_acc_s <= r_acc_m;
            r_map_m <= MAPROM_ACTIVE;
            r_map_s <= r_map_m;
            r_presc <= r_presc + 1'b1;
            r_pwm   <= r_pwm + 1'b1;
        end
    end

    assign w_tick = &r_presc;
    assign w_dim  = (r_pwm < c_DIM_DUTY);

    // A fresh access reloads the stretch even if a tick decrement lands in the same cycle.
    always_ff @(posedge CLK_E or negedge RESET) begin
        if (!RESET) begin
            r_hold    <= 8'd0;
            LED_ACCEL <= 1'b0;
        end else begin
            if (!r_acc_s) begin
                r_hold <= 8'd0;
            end else if (w_event) begin
                r_hold <= c_HOLD_LOAD;
            end else if (w_tick && (r_hold != 8'd0)) begin
                r_hold <= r_hold - 8'd1;
            end
            LED_ACCEL <= r_acc_s & ((r_hold != 8'd0) | w_dim);
        end
    end

    assign w_phase_end = w_tick && (r_tcnt == c_BLINK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_bc_nxt    = r_bc;
        if (!r_map_s) begin
            w_state_nxt = ST_IDLE;
            w_tcnt_nxt  = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_bc_nxt    = c_BC_LOAD;
                    w_tcnt_nxt  = 8'd0;
                    w_state_nxt = (c_BC_LOAD == 8'd0) ? ST_STEADY : ST_BLINK_ON;
                end
                ST_BLINK_ON: begin
                    if (w_phase_end) begin
                        w_state_nxt = ST_BLINK_OFF;
                        w_tcnt_nxt  = 8'd0;
                    end else if (w_tick) begin
                        w_tcnt_nxt  = r_tcnt + 8'd1;
                    end
                end
                ST_BLINK_OFF: begin
                    if (w_phase_end) begin
                        w_tcnt_nxt  = 8'd0;
                        w_bc_nxt    = (r_bc != 8'd0) ? r_bc - 8'd1 : 8'd0;
                        w_state_nxt = (r_bc <= 8'd1) ? ST_STEADY : ST_BLINK_ON;
                    end else if (w_tick) begin
                        w_tcnt_nxt  = r_tcnt + 8'd1;
                    end
                end
                default: begin
                    w_tcnt_nxt  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_E or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_IDLE;
            r_tcnt     <= 8'd0;
            r_bc       <= 8'd0;
            LED_MAPROM <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_bc       <= w_bc_nxt;
            LED_MAPROM <= maprom_led_on(w_state_nxt);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_accel_led_driver.sv
// ============================================================================
// tb_accel_led_driver
// Directed stimulus with a window scoreboard; shortened timing parameters (tick = 8 CLK_E).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_accel_led_driver;

    logic CLK_E = 1'b0;
    logic RESET = 1'b0;
    logic ACCEL_ACTIVE = 1'b0;
    logic MAPROM_ACTIVE = 1'b0;
    logic RAM_CE_n = 1'b1;
    logic LED_ACCEL;
    logic LED_MAPROM;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit active = 1'b0;

    // Each window: over len samples from cycle start, either every masked sample equals ex,
    // or (cnt_mode) the number of samples with any masked bit high equals ex.
    typedef struct {
        string      name;
        int         start;
        int         len;
        logic [1:0] mask;
        bit         cnt_mode;
        int         ex;
    } win_t;

    win_t q[$];

    accel_led_driver #(
        .PRESCALE_BITS (3),
        .HOLD_TICKS    (5),
        .PWM_BITS      (4),
        .DIM_DUTY      (3),
        .BLINK_TICKS   (4),
        .BLINK_COUNT   (3)
    ) dut (
        .CLK_E         (CLK_E),
        .RESET         (RESET),
        .ACCEL_ACTIVE  (ACCEL_ACTIVE),
        .MAPROM_ACTIVE (MAPROM_ACTIVE),
        .RAM_CE_n      (RAM_CE_n),
        .LED_ACCEL     (LED_ACCEL),
        .LED_MAPROM    (LED_MAPROM)
    );

    always #10 CLK_E = ~CLK_E;
    always @(posedge CLK_E) cyc <= cyc + 1;

    task automatic step(input int k);
        repeat (k) begin
            @(posedge CLK_E);
            #2;
        end
    endtask

    task automatic push(input string nm, input int st, input int ln,
                        input logic [1:0] mk, input bit cm, input int ex);
        win_t w;
        w.name = nm; w.start = st; w.len = ln; w.mask = mk; w.cnt_mode = cm; w.ex = ex;
        q.push_back(w);
    endtask

    task automatic ce_pulse();
        RAM_CE_n = 1'b0;
        #6;
        RAM_CE_n = 1'b1;
    endtask

    // Monitor: opens the head window when its start cycle arrives and scores it on completion.
    initial begin
        win_t       w;
        int         seen, ones, bad_cyc;
        bit         bad;
        logic [1:0] leds, bad_val;
        seen = 0; ones = 0; bad = 1'b0; bad_cyc = 0; bad_val = 2'b00;
        forever begin
            @(negedge CLK_E);
            if (!active) begin
                while (q.size() > 0 && q[0].start < cyc) begin
                    w = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL %s: window start %0d missed, now cycle %0d", w.name, w.start, cyc);
                end
                if (q.size() > 0 && q[0].start == cyc) begin
                    w = q.pop_front();
                    active = 1'b1;
                    seen = 0; ones = 0; bad = 1'b0;
                end
            end
            if (active) begin
                leds = {LED_ACCEL, LED_MAPROM};
                if ((leds & w.mask) != 2'b00) ones++;
                if (!w.cnt_mode && !bad && ((leds & w.mask) != 2'(w.ex))) begin
                    bad = 1'b1; bad_cyc = cyc; bad_val = leds;
                end
                seen++;
                if (seen == w.len) begin
                    active = 1'b0;
                    checks++;
                    if (w.cnt_mode && ones != w.ex) begin
                        errors++;
                        $display("FAIL %s: high count %0d over %0d cycles, expected %0d",
                                 w.name, ones, w.len, w.ex);
                    end else if (!w.cnt_mode && bad) begin
                        errors++;
                        $display("FAIL %s: cycle %0d {LED_ACCEL,LED_MAPROM}=%b mask %b, expected %b",
                                 w.name, bad_cyc, bad_val, w.mask, 2'(w.ex));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, r;
        step(1);

        // Reset held while every input toggles
        n = cyc;
        push("reset_hold", n, 20, 2'b11, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            ACCEL_ACTIVE  = ~ACCEL_ACTIVE;
            MAPROM_ACTIVE = ~MAPROM_ACTIVE;
            RAM_CE_n      = ~RAM_CE_n;
            step(1);
        end
        RAM_CE_n = 1'b1; ACCEL_ACTIVE = 1'b1; MAPROM_ACTIVE = 1'b0;
        RESET = 1'b1;

        // Dim glow: 3 of every 16 cycles
        step(10);
        n = cyc;
        push("pwm_a", n, 16, 2'b10, 1'b1, 3);
        push("pwm_b", n + 16, 16, 2'b10, 1'b1, 3);
        push("pwm_c", n + 32, 16, 2'b10, 1'b1, 3);
        push("maprom_idle", n + 48, 16, 2'b01, 1'b0, 0);
        step(64);

        // Single access: on by the 4th edge, stretched at least 4 full ticks
        n = cyc;
        push("hold_on", n + 4, 33, 2'b10, 1'b0, 2);
        push("hold_end", n + 46, 16, 2'b10, 1'b1, 3);
        ce_pulse();
        step(64);

        // Retrigger 20 cycles in: continuous on until the reloaded stretch expires
        n = cyc;
        push("retrig_on", n + 4, 53, 2'b10, 1'b0, 2);
        push("retrig_end", n + 66, 16, 2'b10, 1'b1, 3);
        ce_pulse();
        step(20);
        ce_pulse();
        step(70);

        // Dropping ACCEL_ACTIVE forces off and discards the stretch
        n = cyc;
        push("accdrop_off", n + 13, 10, 2'b10, 1'b0, 0);
        push("accdrop_clr", n + 30, 16, 2'b10, 1'b1, 3);
        ce_pulse();
        step(10);
        ACCEL_ACTIVE = 1'b0;
        step(13);
        ACCEL_ACTIVE = 1'b1;
        step(40);

        // MapROM active through reset release: 3 blinks of 32 cycles then steady
        RESET = 1'b0; ACCEL_ACTIVE = 1'b0; MAPROM_ACTIVE = 1'b1;
        step(5);
        r = cyc;
        push("blink_on1",  r + 3,   29, 2'b11, 1'b0, 1);
        push("blink_off1", r + 32,  32, 2'b11, 1'b0, 0);
        push("blink_on2",  r + 64,  32, 2'b11, 1'b0, 1);
        push("blink_off2", r + 96,  32, 2'b11, 1'b0, 0);
        push("blink_on3",  r + 128, 32, 2'b11, 1'b0, 1);
        push("blink_off3", r + 160, 32, 2'b11, 1'b0, 0);
        push("steady_on",  r + 192, 20, 2'b11, 1'b0, 1);
        RESET = 1'b1;
        step(215);

        // MAPROM_ACTIVE dropped in the second on phase: off 3 edges later and stays idle
        RESET = 1'b0;
        step(3);
        r = cyc;
        push("drop_pre",  r + 64, 9,  2'b11, 1'b0, 1);
        push("drop_idle", r + 73, 30, 2'b11, 1'b0, 0);
        RESET = 1'b1;
        step(70);
        MAPROM_ACTIVE = 1'b0;
        step(40);

        // Reset during a hold: immediate clear, no phantom access after release
        ACCEL_ACTIVE = 1'b1;
        step(10);
        n = cyc;
        push("rst_hold_on", n + 4, 6, 2'b10, 1'b0, 2);
        ce_pulse();
        step(10);
        push("rst_hold_off", n + 10, 5, 2'b11, 1'b0, 0);
        RESET = 1'b0;
        step(5);
        RESET = 1'b1;
        push("rst_hold_noevt", n + 25, 16, 2'b10, 1'b1, 3);
        step(45);

        // Reset during BLINK_ON: immediate clear, blinking restarts on the 3rd edge
        ACCEL_ACTIVE = 1'b0; MAPROM_ACTIVE = 1'b1;
        n = cyc;
        push("blink_pre", n + 3, 7, 2'b11, 1'b0, 1);
        step(10);
        push("rst_blink_off", n + 10, 5, 2'b11, 1'b0, 0);
        RESET = 1'b0;
        step(5);
        r = cyc;
        RESET = 1'b1;
        push("blink_restart", r + 3, 29, 2'b11, 1'b0, 1);
        push("blink_restart_off", r + 32, 10, 2'b11, 1'b0, 0);
        step(50);

        for (int i = 0; i < 300 && (q.size() > 0 || active); i++) step(1);
        if (q.size() > 0 || active) begin
            errors++;
            $display("FAIL drain: %0d windows still pending, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
